// File: rtl/rx_udp.sv
// UDP receive stage: strips and parses the 8-byte UDP header from the IP payload stream,
// filters on protocol/port/length, and forwards the payload trimmed to the UDP length.
module rx_udp #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        s_axis_aclk,
  input  logic        rst,
  input  logic        udp_enable,
  input  logic [15:0] listen_port,
  input  logic [15:0] IP_TotLen,
  input  logic [7:0]  IP_Protocol,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] UDP_SrcPort,
  output logic [15:0] UDP_DestPort,
  output logic [15:0] UDP_Len,
  output logic        udp_drop,
  output logic        udp_len_err
);

  localparam int unsigned HDR_LAST = 7;
  localparam logic [7:0]  PROTO_UDP = 8'd17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_WAIT_LAST,
    S_DROP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       m_tdata_q, m_tdata_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic             m_tuser_q, m_tuser_d;
  logic             m_tlast_q, m_tlast_d;
  logic [15:0]      src_q, src_d;
  logic [15:0]      dst_q, dst_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      csum_q, csum_d;
  logic             drop_q, drop_d;
  logic             len_err_q, len_err_d;

  logic             len_short_c;
  logic             len_long_c;
  logic             hdr_reject_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [CNT_W-1:0] pay_len_c;

  // Header checks use the length field completed on byte 5, evaluated at byte 7
  assign len_short_c  = len_q < 16'd8;
  assign len_long_c   = len_q > (IP_TotLen - 16'd20);
  assign hdr_reject_c = (IP_Protocol != PROTO_UDP) || (dst_q != listen_port) ||
                        len_short_c || len_long_c;
  assign cnt_inc_c    = cnt_q + CNT_W'(1);
  assign pay_len_c    = CNT_W'(len_q - 16'd8);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = 1'b0;
    m_tuser_d  = 1'b0;
    m_tlast_d  = 1'b0;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    csum_d     = csum_q;
    drop_d     = 1'b0;
    len_err_d  = 1'b0;

    if (udp_enable && s_axis_tvalid) begin
      case (state_q)
        S_IDLE: begin
          if (s_axis_tuser) begin
            state_d     = S_HEADER;
            cnt_d       = CNT_W'(1);
            src_d[15:8] = s_axis_tdata;
          end
        end

        S_HEADER: begin
          if (s_axis_tlast) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            len_err_d = 1'b1;
          end else begin
            cnt_d = cnt_inc_c;
            case (cnt_q[2:0])
              3'd1: src_d[7:0]   = s_axis_tdata;
              3'd2: dst_d[15:8]  = s_axis_tdata;
              3'd3: dst_d[7:0]   = s_axis_tdata;
              3'd4: len_d[15:8]  = s_axis_tdata;
              3'd5: len_d[7:0]   = s_axis_tdata;
              3'd6: csum_d[15:8] = s_axis_tdata;
              default: csum_d[7:0] = s_axis_tdata;
            endcase
            if (cnt_q == CNT_W'(HDR_LAST)) begin
              cnt_d = '0;
              if (hdr_reject_c) begin
                state_d   = S_DROP;
                drop_d    = 1'b1;
                len_err_d = len_short_c || len_long_c;
              end else if (len_q == 16'd8) begin
                state_d = S_WAIT_LAST;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          m_tdata_d  = s_axis_tdata;
          m_tvalid_d = 1'b1;
          m_tuser_d  = (cnt_q == '0);
          cnt_d      = cnt_inc_c;
          if (cnt_inc_c == pay_len_c) begin
            m_tlast_d = 1'b1;
            cnt_d     = '0;
            state_d   = s_axis_tlast ? S_IDLE : S_WAIT_LAST;
          end else if (s_axis_tlast) begin
            // Frame ended before the UDP length was satisfied
            m_tlast_d = 1'b1;
            len_err_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end
        end

        S_WAIT_LAST, S_DROP: begin
          if (s_axis_tuser) begin
            state_d     = S_HEADER;
            cnt_d       = CNT_W'(1);
            src_d[15:8] = s_axis_tdata;
          end else if (s_axis_tlast) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      drop_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      drop_q     <= drop_d;
      len_err_q  <= len_err_d;
    end
  end

  // Bypass routes the raw stream straight through when parsing is disabled
  assign s_axis_tready = udp_enable ? 1'b1       : m_axis_tready;
  assign m_axis_tdata  = udp_enable ? m_tdata_q  : s_axis_tdata;
  assign m_axis_tvalid = udp_enable ? m_tvalid_q : s_axis_tvalid;
  assign m_axis_tuser  = udp_enable ? m_tuser_q  : s_axis_tuser;
  assign m_axis_tlast  = udp_enable ? m_tlast_q  : s_axis_tlast;

  assign UDP_SrcPort  = src_q;
  assign UDP_DestPort = dst_q;
  assign UDP_Len      = len_q;
  assign udp_drop     = drop_q;
  assign udp_len_err  = len_err_q;

endmodule

// File: tb/tb_rx_udp.sv
// Scoreboard bench for rx_udp: directed packets push expected payload beats,
// an independent monitor pops and compares each forwarded beat.
module tb_rx_udp;

  typedef struct packed {
    logic [7:0]  d;
    logic        u;
    logic        l;
    logic [31:0] cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        udp_enable = 1'b1;
  logic [15:0] listen_port = 16'h1F90;
  logic [15:0] ip_totlen = 16'd32;
  logic [7:0]  ip_proto = 8'd17;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tuser;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic [15:0] udp_src;
  logic [15:0] udp_dst;
  logic [15:0] udp_len;
  logic        udp_drop;
  logic        udp_len_err;

  int          checks = 0;
  int          errors = 0;
  int          drop_seen = 0;
  int          lenerr_seen = 0;
  logic [31:0] cyc = 0;
  logic        byp = 1'b0;
  beat_t       exp_q[$];
  logic [7:0]  tx_q[$];

  rx_udp #(.CNT_W(16)) dut (
    .s_axis_aclk  (clk),
    .rst          (rst),
    .udp_enable   (udp_enable),
    .listen_port  (listen_port),
    .IP_TotLen    (ip_totlen),
    .IP_Protocol  (ip_proto),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tuser (s_tuser),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tuser (m_tuser),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .UDP_SrcPort  (udp_src),
    .UDP_DestPort (udp_dst),
    .UDP_Len      (udp_len),
    .udp_drop     (udp_drop),
    .udp_len_err  (udp_len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every forwarded beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (udp_drop) drop_seen++;
    if (udp_len_err) lenerr_seen++;
    if (!byp && m_tvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h user %0b last %0b with nothing expected",
                 m_tdata, m_tuser, m_tlast);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (m_tdata !== e.d || m_tuser !== e.u || m_tlast !== e.l || cyc !== e.cyc) begin
          errors++;
          $display("FAIL beat: got d=%0h u=%0b l=%0b cyc=%0d expected d=%0h u=%0b l=%0b cyc=%0d",
                   m_tdata, m_tuser, m_tlast, cyc, e.d, e.u, e.l, e.cyc);
        end
      end
    end
  end

  // Fill tx_q with an 8-byte UDP header followed by nafter payload/padding bytes
  task automatic build(input logic [15:0] src, input logic [15:0] dst,
                       input logic [15:0] len, input int nafter);
    tx_q.delete();
    tx_q.push_back(src[15:8]);
    tx_q.push_back(src[7:0]);
    tx_q.push_back(dst[15:8]);
    tx_q.push_back(dst[7:0]);
    tx_q.push_back(len[15:8]);
    tx_q.push_back(len[7:0]);
    tx_q.push_back(8'hC5);
    tx_q.push_back(8'h3A);
    for (int i = 0; i < nafter; i++) tx_q.push_back(8'(8'hAA + 8'h11 * i));
  endtask

  // Send the first nsend bytes of tx_q; payload bytes below nfwd are expected at the output
  task automatic send(input int nsend, input int nfwd);
    for (int i = 0; i < nsend; i++) begin
      @(negedge clk);
      s_tdata  = tx_q[i];
      s_tvalid = 1'b1;
      s_tuser  = (i == 0);
      s_tlast  = (i == tx_q.size() - 1);
      if (i >= 8 && (i - 8) < nfwd) begin
        beat_t b;
        b.d   = tx_q[i];
        b.u   = (i == 8);
        b.l   = ((i - 8) == nfwd - 1);
        b.cyc = cyc + 1;
        exp_q.push_back(b);
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pkt(input string name, input int nfwd, input int exp_drop, input int exp_lerr);
    int d0, l0;
    d0 = drop_seen;
    l0 = lenerr_seen;
    send(tx_q.size(), nfwd);
    repeat (3) @(negedge clk);
    chk({name, "_drop"}, 32'(drop_seen - d0), 32'(exp_drop));
    chk({name, "_len_err"}, 32'(lenerr_seen - l0), 32'(exp_lerr));
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_src", 32'(udp_src), 32'd0);
    chk("rst_len", 32'(udp_len), 32'd0);
    chk("rst_drop", 32'(udp_drop), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic 4-byte payload
    ip_totlen = 16'd32;
    build(16'h1234, 16'h1F90, 16'h000C, 4);
    pkt("basic", 4, 0, 0);
    chk("basic_src", 32'(udp_src), 32'h1234);
    chk("basic_dst", 32'(udp_dst), 32'h1F90);
    chk("basic_len", 32'(udp_len), 32'h000C);

    // 10 payload bytes followed by 18 padding bytes
    ip_totlen = 16'd38;
    build(16'h4321, 16'h1F90, 16'h0012, 28);
    pkt("padded", 10, 0, 0);
    chk("padded_len", 32'(udp_len), 32'h0012);

    // Wrong destination port, then a good packet
    ip_totlen = 16'd32;
    build(16'h1234, 16'h0035, 16'h000C, 4);
    pkt("badport", 0, 1, 0);
    build(16'h1234, 16'h1F90, 16'h000C, 4);
    pkt("after_badport", 4, 0, 0);

    // ICMP protocol
    ip_proto = 8'd1;
    build(16'h1234, 16'h1F90, 16'h000C, 4);
    pkt("icmp", 0, 1, 0);
    ip_proto = 8'd17;

    // Length below header size
    build(16'h1234, 16'h1F90, 16'h0004, 4);
    pkt("len_short", 0, 1, 1);

    // Length larger than IP payload allows
    ip_totlen = 16'd30;
    build(16'h1234, 16'h1F90, 16'h000C, 4);
    pkt("len_long", 0, 1, 1);

    // Header-only datagram: no output, no pulses
    ip_totlen = 16'd28;
    build(16'h1234, 16'h1F90, 16'h0008, 2);
    pkt("len8", 0, 0, 0);

    // Truncated payload: 6 of 24 bytes before tlast
    ip_totlen = 16'd52;
    build(16'h1234, 16'h1F90, 16'h0020, 6);
    pkt("trunc", 6, 0, 1);

    // tlast inside the header
    build(16'h1234, 16'h1F90, 16'h000C, 0);
    while (tx_q.size() > 5) void'(tx_q.pop_back());
    pkt("hdr_trunc", 0, 0, 1);

    // Reset in the middle of the payload
    ip_totlen = 16'd32;
    build(16'h1234, 16'h1F90, 16'h000C, 4);
    send(10, 4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_m_tuser", 32'(m_tuser), 32'd0);
    chk("midrst_len", 32'(udp_len), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    build(16'h5678, 16'h1F90, 16'h000C, 4);
    pkt("after_rst", 4, 0, 0);
    chk("after_rst_src", 32'(udp_src), 32'h5678);

    // Bypass mirrors the raw stream combinationally
    @(negedge clk);
    byp = 1'b1;
    @(negedge clk);
    #1;
    udp_enable = 1'b0;
    m_tready   = 1'b0;
    s_tdata    = 8'h5A;
    s_tvalid   = 1'b1;
    s_tuser    = 1'b1;
    s_tlast    = 1'b0;
    #1;
    chk("byp_tdata", 32'(m_tdata), 32'h5A);
    chk("byp_tvalid", 32'(m_tvalid), 32'd1);
    chk("byp_tuser", 32'(m_tuser), 32'd1);
    chk("byp_tlast", 32'(m_tlast), 32'd0);
    chk("byp_tready0", 32'(s_tready), 32'd0);
    m_tready = 1'b1;
    s_tlast  = 1'b1;
    s_tuser  = 1'b0;
    #1;
    chk("byp_tready1", 32'(s_tready), 32'd1);
    chk("byp_tlast1", 32'(m_tlast), 32'd1);
    @(negedge clk);
    #1;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    udp_enable = 1'b1;
    @(negedge clk);
    byp = 1'b0;
    chk("enabled_tready", 32'(s_tready), 32'd1);

    // Parsing resumes normally after bypass
    build(16'h9ABC, 16'h1F90, 16'h000C, 4);
    pkt("after_byp", 4, 0, 0);

    repeat (3) @(negedge clk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
